// File: rtl/i_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i_cache_pkg
//  Description : Shared types, width derivation and address-field helpers
//                for the N-way set-associative instruction cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package i_cache_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_FILL   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_REREAD = 3'd4
  } state_e;

  // Ceiling log2; returns 0 for an argument of 1
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  function automatic int off_width(input int block_words);
    return clog2(block_words);
  endfunction

  function automatic int idx_width(input int sets);
    return clog2(sets);
  endfunction

  // The 30 word-address bits split into tag, index and word offset
  function automatic int tag_width(input int block_words, input int sets);
    return 30 - clog2(block_words) - clog2(sets);
  endfunction

  localparam int DEF_WAYS        = 2;
  localparam int DEF_SETS        = 256;
  localparam int DEF_BLOCK_WORDS = 16;

  // Word-within-line field
  function automatic logic [31:0] addr_word(input logic [31:0] addr, input int off_w);
    return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
  endfunction

  // Set index field
  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int off_w,
                                             input int idx_w);
    return (addr >> (off_w + 2)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag field
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_w,
                                           input int idx_w);
    return addr >> (off_w + idx_w + 2);
  endfunction

  // Word address of the first word of the line holding addr
  function automatic logic [31:0] line_word_addr(input logic [31:0] addr, input int off_w);
    return (addr >> (off_w + 2)) << off_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i_cache_way.sv
`default_nettype none
// ============================================================================
//  Module      : i_cache_way
//  Description : One cache way: tag and line arrays (no reset) with a
//                registered read port, a write port and a valid-bit flop
//                vector that can be cleared in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module i_cache_way
  import i_cache_pkg::*;
#(
  parameter  int SETS        = DEF_SETS,
  parameter  int BLOCK_WORDS = DEF_BLOCK_WORDS,
  localparam int IDX_W       = idx_width(SETS),
  localparam int TAG_W       = tag_width(BLOCK_WORDS, SETS)
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         rd_en,
  input  logic [IDX_W-1:0]             rd_idx,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [TAG_W-1:0]             wr_tag,
  input  logic [BLOCK_WORDS-1:0][31:0] wr_data,
  input  logic                         flush_clr,
  input  logic [IDX_W-1:0]             vld_idx,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [BLOCK_WORDS-1:0][31:0] rd_data,
  output logic                         vld
);

  logic [TAG_W-1:0]             tag_mem  [SETS];
  logic [BLOCK_WORDS-1:0][31:0] data_mem [SETS];

  logic [SETS-1:0]              valid_q, valid_d;
  logic [TAG_W-1:0]             rd_tag_q, rd_tag_d;
  logic [BLOCK_WORDS-1:0][31:0] rd_data_q, rd_data_d;

  // Array write port; contents are meaningless until the valid bit is set
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Next values for the read registers and valid bits; a write after a
  // flush in the same cycle cannot happen, but the write wins if it did
  always_comb begin
    rd_tag_d  = rd_tag_q;
    rd_data_d = rd_data_q;
    valid_d   = valid_q;
    if (rd_en) begin
      rd_tag_d  = tag_mem[rd_idx];
      rd_data_d = data_mem[rd_idx];
    end
    if (flush_clr) begin
      valid_d = '0;
    end
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  // Read registers and valid bits
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rd_tag_q  <= '0;
      rd_data_q <= '0;
      valid_q   <= '0;
    end else begin
      rd_tag_q  <= rd_tag_d;
      rd_data_q <= rd_data_d;
      valid_q   <= valid_d;
    end
  end

  assign rd_tag  = rd_tag_q;
  assign rd_data = rd_data_q;
  assign vld     = valid_q[vld_idx];

endmodule
`default_nettype wire

// File: rtl/i_cache_nway.sv
`default_nettype none
// ============================================================================
//  Module      : i_cache_nway
//  Description : N-way set-associative instruction cache. Lookup FSM, DRAM
//                line refill, per-set round-robin victim choice that prefers
//                invalid ways, and whole-cache flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module i_cache_nway
  import i_cache_pkg::*;
#(
  parameter  int WAYS        = DEF_WAYS,
  parameter  int SETS        = DEF_SETS,
  parameter  int BLOCK_WORDS = DEF_BLOCK_WORDS,
  localparam int OFF_W       = off_width(BLOCK_WORDS),
  localparam int IDX_W       = idx_width(SETS),
  localparam int TAG_W       = tag_width(BLOCK_WORDS, SETS),
  localparam int WAY_W       = (WAYS > 1) ? clog2(WAYS) : 1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        ins_req,
  input  logic        flush,
  output logic [31:0] instruction,
  output logic        hit,
  output logic        rom_abort,
  input  logic [31:0] dram_rd_data,
  input  logic        dram_val,
  output logic        dram_rd_req,
  output logic [31:0] dram_rd_addr
);

  state_e                       state_q, state_d;
  logic [31:0]                  addr_buf_q, addr_buf_d;
  logic [OFF_W-1:0]             cnt_q, cnt_d;
  logic [BLOCK_WORDS-1:0][31:0] line_buf_q, line_buf_d;
  logic [WAY_W-1:0]             rr_ptr_q [SETS];
  logic [WAY_W-1:0]             rr_ptr_d [SETS];
  logic                         dram_rd_req_q, dram_rd_req_d;
  logic [31:0]                  dram_rd_addr_q, dram_rd_addr_d;

  logic [IDX_W-1:0]             buf_idx, req_idx, rd_idx;
  logic [TAG_W-1:0]             buf_tag;
  logic [OFF_W-1:0]             buf_word;
  logic                         can_accept, accept, flush_ok, rd_en, lookup_hit;
  logic [TAG_W-1:0]             way_tag  [WAYS];
  logic [BLOCK_WORDS-1:0][31:0] way_data [WAYS];
  logic [WAYS-1:0]              way_valid, way_hit, way_wr;
  logic [WAY_W-1:0]             victim;
  logic                         victim_found;

  assign buf_idx  = IDX_W'(addr_index(addr_buf_q, OFF_W, IDX_W));
  assign buf_tag  = TAG_W'(addr_tag(addr_buf_q, OFF_W, IDX_W));
  assign buf_word = OFF_W'(addr_word(addr_buf_q, OFF_W));
  assign req_idx  = IDX_W'(addr_index(cpu_addr, OFF_W, IDX_W));

  // A new fetch is taken in IDLE, or in LOOKUP once the current one has hit
  assign can_accept = (state_q == ST_IDLE) || ((state_q == ST_LOOKUP) && lookup_hit);
  assign accept     = ins_req && can_accept;
  assign flush_ok   = flush && ((state_q == ST_IDLE) || (state_q == ST_LOOKUP));
  assign rd_en      = accept || (state_q == ST_REREAD);
  assign rd_idx     = (state_q == ST_REREAD) ? buf_idx : req_idx;

  genvar gw;
  generate
    for (gw = 0; gw < WAYS; gw++) begin : g_way
      assign way_wr[gw] = (state_q == ST_WRITE) && (victim == WAY_W'(gw));

      i_cache_way #(
        .SETS        (SETS),
        .BLOCK_WORDS (BLOCK_WORDS)
      ) u_way (
        .clock     (clock),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .wr_en     (way_wr[gw]),
        .wr_idx    (buf_idx),
        .wr_tag    (buf_tag),
        .wr_data   (line_buf_q),
        .flush_clr (flush_ok),
        .vld_idx   (buf_idx),
        .rd_tag    (way_tag[gw]),
        .rd_data   (way_data[gw]),
        .vld       (way_valid[gw])
      );

      assign way_hit[gw] = way_valid[gw] && (way_tag[gw] == buf_tag);
    end
  endgenerate

  assign lookup_hit = |way_hit;
  assign hit        = (state_q == ST_LOOKUP) && lookup_hit;

  // Word from the matching way; lowest-numbered match wins
  always_comb begin
    instruction = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        instruction = way_data[w][buf_word];
      end
    end
  end

  // Victim: first invalid way in the set, else the set's round-robin pointer
  always_comb begin
    victim       = rr_ptr_q[buf_idx];
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!way_valid[w] && !victim_found) begin
        victim       = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d        = state_q;
    addr_buf_d     = addr_buf_q;
    cnt_d          = cnt_q;
    line_buf_d     = line_buf_q;
    rr_ptr_d       = rr_ptr_q;
    dram_rd_req_d  = dram_rd_req_q;
    dram_rd_addr_d = dram_rd_addr_q;
    rom_abort      = 1'b0;

    if (flush_ok) begin
      for (int s = 0; s < SETS; s++) begin
        rr_ptr_d[s] = '0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (ins_req) begin
          addr_buf_d = cpu_addr;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (lookup_hit) begin
          if (ins_req) begin
            addr_buf_d = cpu_addr;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          rom_abort      = 1'b1;
          state_d        = ST_FILL;
          dram_rd_req_d  = 1'b1;
          dram_rd_addr_d = line_word_addr(addr_buf_q, OFF_W);
          cnt_d          = '0;
        end
      end
      ST_FILL: begin
        rom_abort = 1'b1;
        if (dram_val) begin
          line_buf_d[cnt_q] = dram_rd_data;
          cnt_d             = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(BLOCK_WORDS - 1)) begin
            cnt_d         = '0;
            dram_rd_req_d = 1'b0;
            state_d       = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        rom_abort = 1'b1;
        // Filling an empty way leaves the rotation where it was
        if (!victim_found) begin
          rr_ptr_d[buf_idx] = (rr_ptr_q[buf_idx] == WAY_W'(WAYS - 1)) ? '0
                              : rr_ptr_q[buf_idx] + WAY_W'(1);
        end
        state_d = ST_REREAD;
      end
      ST_REREAD: begin
        rom_abort = 1'b1;
        state_d   = ST_LOOKUP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      addr_buf_q     <= '0;
      cnt_q          <= '0;
      dram_rd_req_q  <= 1'b0;
      dram_rd_addr_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_ptr_q[s] <= '0;
      end
    end else begin
      state_q        <= state_d;
      addr_buf_q     <= addr_buf_d;
      cnt_q          <= cnt_d;
      dram_rd_req_q  <= dram_rd_req_d;
      dram_rd_addr_q <= dram_rd_addr_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  // Refill staging buffer; only written into a way after a complete burst
  always_ff @(posedge clock) begin
    line_buf_q <= line_buf_d;
  end

  assign dram_rd_req  = dram_rd_req_q;
  assign dram_rd_addr = dram_rd_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_i_cache_nway.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i_cache_nway
//  Description : Self-checking bench for i_cache_nway (default parameters).
//                Directed scenarios followed by randomized fetch/flush traffic
//                checked against a set/way occupancy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i_cache_nway;

  localparam int NSETS = 256;
  localparam int NWAYS = 2;
  localparam int NWORD = 16;

  logic        clock = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        ins_req;
  logic        flush;
  logic [31:0] instruction;
  logic        hit;
  logic        rom_abort;
  logic [31:0] dram_rd_data;
  logic        dram_val;
  logic        dram_rd_req;
  logic [31:0] dram_rd_addr;

  int n_cmp = 0;
  int n_mis = 0;

  // Occupancy model: which tag sits in which way of each set
  bit          m_valid [NSETS][NWAYS];
  int unsigned m_tag   [NSETS][NWAYS];
  int          m_rr    [NSETS];

  i_cache_nway dut (
    .clock        (clock),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .ins_req      (ins_req),
    .flush        (flush),
    .instruction  (instruction),
    .hit          (hit),
    .rom_abort    (rom_abort),
    .dram_rd_data (dram_rd_data),
    .dram_val     (dram_val),
    .dram_rd_req  (dram_rd_req),
    .dram_rd_addr (dram_rd_addr)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // DRAM contents by word address; line 0x410 holds 0xA0..0xAF
  function automatic logic [31:0] dram_word(input logic [31:0] wa);
    if ((wa >> 4) == 32'h41) return 32'hA0 + (wa & 32'hF);
    return (wa * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 6) & 32'hFF);
  endfunction

  function automatic int unsigned m_tg(input logic [31:0] a);
    return a >> 14;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < NSETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  function automatic bit m_lookup(input logic [31:0] a);
    for (int w = 0; w < NWAYS; w++)
      if (m_valid[m_idx(a)][w] && m_tag[m_idx(a)][w] == m_tg(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_install(input logic [31:0] a);
    int s, v;
    s = m_idx(a);
    v = -1;
    for (int w = 0; w < NWAYS; w++)
      if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % NWAYS;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = m_tg(a);
  endfunction

  // One fetch starting at a negedge where the cache can accept; ends at the
  // negedge where the fetch is observed hitting in LOOKUP
  task automatic do_fetch(input logic [31:0] a, input bit fl_req, input bit fl_fill);
    bit          exp_hit;
    logic [31:0] base;
    cpu_addr = a;
    ins_req  = 1'b1;
    flush    = fl_req;
    @(negedge clock);
    ins_req = 1'b0;
    flush   = 1'b0;
    if (fl_req) m_clear();
    exp_hit = m_lookup(a);
    chk("lookup_hit", hit, exp_hit);
    chk("lookup_abort", rom_abort, !exp_hit);
    if (exp_hit) begin
      chk("hit_instr", instruction, dram_word(a >> 2));
      return;
    end
    chk("miss_req_low", dram_rd_req, 1'b0);
    // stray DRAM word before FILL must be ignored
    dram_val     = 1'b1;
    dram_rd_data = 32'hDEAD_BEEF;
    @(negedge clock);
    dram_val = 1'b0;
    base = (a >> 6) << 4;
    chk("fill_req", dram_rd_req, 1'b1);
    chk("fill_addr", dram_rd_addr, base);
    chk("fill_abort", rom_abort, 1'b1);
    if (fl_fill) flush = 1'b1;
    for (int i = 0; i < NWORD; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      dram_val     = 1'b1;
      dram_rd_data = dram_word(base + 32'(i));
      @(negedge clock);
      dram_val     = 1'b0;
      dram_rd_data = $urandom;
    end
    chk("write_req", dram_rd_req, 1'b0);
    chk("write_abort", rom_abort, 1'b1);
    m_install(a);
    @(negedge clock);
    chk("reread_abort", rom_abort, 1'b1);
    flush = 1'b0;
    @(negedge clock);
    chk("refill_hit", hit, 1'b1);
    chk("refill_abort", rom_abort, 1'b0);
    chk("refill_instr", instruction, dram_word(a >> 2));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    m_clear();
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    rst          = 1'b1;
    ins_req      = 1'b0;
    flush        = 1'b0;
    cpu_addr     = '0;
    dram_val     = 1'b0;
    dram_rd_data = '0;
    m_clear();
    repeat (2) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    chk("rst_hit", hit, 1'b0);
    chk("rst_abort", rom_abort, 1'b0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_req", dram_rd_req, 1'b0);
    chk("rst_addr", dram_rd_addr, 32'h0);

    // cold miss then consecutive hits in the same line
    do_fetch(32'h0000_1048, 0, 0);
    chk("cold_instr", instruction, 32'hA2);
    do_fetch(32'h0000_1040, 0, 0);
    chk("b2b_0", instruction, 32'hA0);
    do_fetch(32'h0000_1044, 0, 0);
    chk("b2b_1", instruction, 32'hA1);
    do_fetch(32'h0000_107C, 0, 0);
    chk("b2b_2", instruction, 32'hAF);

    // conflict fill into way1, eviction of way0 by round robin
    do_fetch(32'h0000_5040, 0, 0);
    do_fetch(32'h0000_1040, 0, 0);
    do_fetch(32'h0000_5040, 0, 0);
    do_fetch(32'h0000_9040, 0, 0);
    do_fetch(32'h0000_5040, 0, 0);
    do_fetch(32'h0000_1040, 0, 0);

    // flush from LOOKUP, flush with a request, flush held through a refill
    do_flush();
    do_fetch(32'h0000_1040, 0, 0);
    do_fetch(32'h0000_9040, 0, 0);
    do_fetch(32'h0000_9040, 1, 0);
    do_fetch(32'h0000_2004, 0, 1);
    do_fetch(32'h0000_2008, 0, 0);

    // reset part-way through a burst
    cpu_addr = 32'h0000_3048;
    ins_req  = 1'b1;
    @(negedge clock);
    ins_req = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 7; i++) begin
      dram_val     = 1'b1;
      dram_rd_data = dram_word(32'h0000_0C10 + 32'(i));
      @(negedge clock);
      dram_val = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midrst_req", dram_rd_req, 1'b0);
    chk("midrst_abort", rom_abort, 1'b0);
    m_clear();
    @(negedge clock);
    rst      = 1'b0;
    dram_val = 1'b1;
    repeat (3) @(negedge clock);
    dram_val = 1'b0;
    chk("postrst_req", dram_rd_req, 1'b0);
    chk("postrst_abort", rom_abort, 1'b0);
    do_fetch(32'h0000_3048, 0, 0);

    // randomized traffic over a few hot sets
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 3);
      a = 32'($urandom_range(0, 4)) << 14;
      case (r)
        0: a = a | (32'h41 << 6);
        1: a = a | (32'h00 << 6);
        2: a = a | (32'hFF << 6);
        default: a = a | (32'($urandom_range(0, 255)) << 6);
      endcase
      a = a | (32'($urandom_range(0, 15)) << 2);
      r = $urandom_range(0, 19);
      if (r == 0) do_flush();
      else do_fetch(a, r == 1, r == 2);
      if ($urandom_range(0, 3) == 0) @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
